// File: rtl/ps2_kbd_fifo_if.sv
// rtl/ps2_kbd_fifo_if.sv - keyboard line and scan-code FIFO bus bundle
// slave  (receiver): in ps2_clk, ps2_data, rd_en, clr_err; out data, ready, count, overflow, frame_err
// master (host)    : the same signals in the opposite direction
interface ps2_kbd_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                          ps2_clk;
  logic                          ps2_data;
  logic                          rd_en;
  logic                          clr_err;
  logic [7:0]                    data;
  logic                          ready;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          overflow;
  logic                          frame_err;

  modport slave (
    input  ps2_clk, ps2_data, rd_en, clr_err,
    output data, ready, count, overflow, frame_err
  );

  modport master (
    output ps2_clk, ps2_data, rd_en, clr_err,
    input  data, ready, count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_kbd_fifo.sv
// rtl/ps2_kbd_fifo.sv - PS/2 keyboard frame receiver feeding a scan-code FIFO
// clk       : system clock, rising edge
// rst       : synchronous active-high reset
// bus.slave : ps2_clk/ps2_data keyboard lines, rd_en pop, clr_err flag clear;
//             data/ready FIFO head, count occupancy, overflow/frame_err sticky flags
module ps2_kbd_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst,
  ps2_kbd_fifo_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             buf_q, buf_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]             mem [FIFO_DEPTH];

  logic fall, frame_done, frame_ok, timeout, pop, push, full;

  // The two oldest synchroniser taps give a metastability-filtered edge.
  assign fall = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = bus.rd_en & (count_q != '0);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
    bitcnt_d   = bitcnt_q;
    buf_d      = buf_q;
    idle_d     = idle_q;
    frame_done = 1'b0;
    timeout    = 1'b0;

    // Idle counter saturates so it never wraps back into the timeout window.
    if (fall) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + IW'(1);
    end

    if (fall) begin
      if (bitcnt_q == 4'd10) begin
        frame_done = 1'b1;
        bitcnt_d   = 4'd0;
      end else begin
        // Shift in at the top so the first (start) bit lands in buf[0].
        buf_d    = {bus.ps2_data, buf_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0 && idle_q == IW'(TIMEOUT_CYCLES)) begin
      timeout  = 1'b1;
      bitcnt_d = 4'd0;
    end
  end

  // Stop bit is the live ps2_data sample; XOR over data+parity must be 1.
  assign frame_ok = frame_done & ~buf_q[0] & bus.ps2_data & (^buf_q[9:1]);
  // When full, a simultaneous pop frees the slot being written.
  assign push     = frame_ok & (~full | pop);

  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Set events win over a same-cycle clear.
    ovf_d  = (frame_ok & full & ~pop) | (ovf_q & ~bus.clr_err);
    ferr_d = (frame_done & ~frame_ok) | timeout | (ferr_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      bitcnt_q <= 4'd0;
      buf_q    <= '0;
      idle_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      bitcnt_q <= bitcnt_d;
      buf_q    <= buf_d;
      idle_q   <= idle_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr_q] <= buf_q[8:1];
    end
  end

  assign bus.data      = mem[rptr_q];
  assign bus.ready     = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// tb/tb_ps2_kbd_fifo.sv - self-checking bench for ps2_kbd_fifo
module tb_ps2_kbd_fifo;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4096;
  localparam int HALF    = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ps2_kbd_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_kbd_fifo #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic [10:0] bits;
    logic        exp_ready;
    logic [7:0]  exp_data;
    int          exp_count;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip,
                                     input logic st, input logic sp);
    return {sp, (~^d) ^ pflip, d, st};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives n bits LSB first; optionally raises rd_en for the cycle the final
  // frame edge is processed (3-stage synchroniser: two cycles after ps2_clk falls).
  task automatic send_bits(input logic [10:0] bits, input int n, input bit align_pop);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (align_pop && i == 10) begin
        @(negedge clk);
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{mk(8'h1C, 1'b0, 1'b0, 1'b1), 1'b1, 8'h1C, 1, 1'b0};
    vecs[1] = '{mk(8'h1C, 1'b1, 1'b0, 1'b1), 1'b0, 8'h00, 0, 1'b1};
    vecs[2] = '{mk(8'hF0, 1'b0, 1'b0, 1'b1), 1'b1, 8'hF0, 1, 1'b0};
    vecs[3] = '{mk(8'h00, 1'b0, 1'b0, 1'b1), 1'b1, 8'h00, 1, 1'b0};
    vecs[4] = '{mk(8'hFF, 1'b0, 1'b0, 1'b1), 1'b1, 8'hFF, 1, 1'b0};
    vecs[5] = '{mk(8'h5A, 1'b0, 1'b1, 1'b1), 1'b0, 8'h00, 0, 1'b1};
    vecs[6] = '{mk(8'h33, 1'b0, 1'b0, 1'b0), 1'b0, 8'h00, 0, 1'b1};
    vecs[7] = '{mk(8'hA5, 1'b1, 1'b0, 1'b1), 1'b0, 8'h00, 0, 1'b1};

    rst = 1'b1;
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", bus.ready, 0);
    chk("reset count", bus.count, 0);
    chk("reset overflow", bus.overflow, 0);
    chk("reset frame_err", bus.frame_err, 0);

    // the spec's literal 0x1C bit sequence
    chk("1C bit pattern", mk(8'h1C, 1'b0, 1'b0, 1'b1), 11'b100_0011_1000);

    for (int v = 0; v < 8; v++) begin
      send_bits(vecs[v].bits, 11, 1'b0);
      chk($sformatf("vec%0d ready", v), bus.ready, vecs[v].exp_ready);
      chk($sformatf("vec%0d count", v), bus.count, vecs[v].exp_count);
      chk($sformatf("vec%0d frame_err", v), bus.frame_err, vecs[v].exp_ferr);
      chk($sformatf("vec%0d overflow", v), bus.overflow, 0);
      if (vecs[v].exp_ready) begin
        chk($sformatf("vec%0d data", v), bus.data, vecs[v].exp_data);
        pop_one();
        chk($sformatf("vec%0d ready after pop", v), bus.ready, 0);
        chk($sformatf("vec%0d count after pop", v), bus.count, 0);
      end else begin
        clr_pulse();
        chk($sformatf("vec%0d frame_err cleared", v), bus.frame_err, 0);
      end
    end

    // rd_en on empty FIFO is ignored
    pop_one();
    chk("empty pop count", bus.count, 0);

    // overflow: 9 frames into 8 entries
    for (int k = 1; k <= 9; k++) send_bits(mk(8'(k), 1'b0, 1'b0, 1'b1), 11, 1'b0);
    chk("ovf count", bus.count, 8);
    chk("ovf flag", bus.overflow, 1);
    chk("ovf frame_err", bus.frame_err, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf pop %0d", k), bus.data, k);
      pop_one();
    end
    chk("ovf drained ready", bus.ready, 0);
    chk("ovf drained count", bus.count, 0);
    chk("ovf sticky", bus.overflow, 1);
    clr_pulse();
    chk("ovf cleared", bus.overflow, 0);

    // full FIFO with pop aligned to completion of 0x5A
    for (int k = 1; k <= 8; k++) send_bits(mk(8'(k), 1'b0, 1'b0, 1'b1), 11, 1'b0);
    chk("full count", bus.count, 8);
    send_bits(mk(8'h5A, 1'b0, 1'b0, 1'b1), 11, 1'b1);
    chk("aligned count", bus.count, 8);
    chk("aligned overflow", bus.overflow, 0);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("aligned pop %0d", k), bus.data, (k == 9) ? 8'h5A : k);
      pop_one();
    end
    chk("aligned drained count", bus.count, 0);

    // partial frame timeout
    send_bits(mk(8'hAA, 1'b0, 1'b0, 1'b1), 5, 1'b0);
    repeat (TIMEOUT - 100) @(negedge clk);
    chk("before timeout frame_err", bus.frame_err, 0);
    repeat (200) @(negedge clk);
    chk("after timeout frame_err", bus.frame_err, 1);
    chk("after timeout ready", bus.ready, 0);
    clr_pulse();
    send_bits(mk(8'hF0, 1'b0, 1'b0, 1'b1), 11, 1'b0);
    chk("post-timeout data", bus.data, 8'hF0);
    chk("post-timeout count", bus.count, 1);
    chk("post-timeout frame_err", bus.frame_err, 0);
    pop_one();

    // reset in the middle of a frame
    send_bits(mk(8'h77, 1'b0, 1'b0, 1'b1), 4, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_bits(mk(8'h32, 1'b0, 1'b0, 1'b1), 11, 1'b0);
    chk("post-reset data", bus.data, 8'h32);
    chk("post-reset count", bus.count, 1);
    chk("post-reset frame_err", bus.frame_err, 0);
    chk("post-reset overflow", bus.overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
